// File: rtl/mseq_pkg.sv
// Shared definitions for the microprogram sequencer: sequencing codes,
// opcode constants, dispatch table select and named microstate addresses.
package mseq_pkg;

  localparam int unsigned SEQ_W = 3;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned MS_W  = 4;

  typedef enum logic [SEQ_W-1:0] {
    NEXT  = 3'b000,
    DISP1 = 3'b001,
    DISP2 = 3'b010,
    FETCH = 3'b011,
    ALUWB = 3'b100
  } seq_e;

  typedef enum logic {
    TBL_DISP1 = 1'b0,
    TBL_DISP2 = 1'b1
  } tbl_e;

  localparam logic [OPC_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_JAL = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_BEQ = 7'b1100011;

  localparam int unsigned S_FETCH    = 0;
  localparam int unsigned S_DECODE   = 1;
  localparam int unsigned S_MEMADR   = 2;
  localparam int unsigned S_MEMREAD  = 3;
  localparam int unsigned S_MEMWB    = 4;
  localparam int unsigned S_MEMWRITE = 5;
  localparam int unsigned S_EXECUTER = 6;
  localparam int unsigned S_ALUWB    = 7;
  localparam int unsigned S_EXECUTEI = 8;
  localparam int unsigned S_JAL      = 9;
  localparam int unsigned S_BEQ      = 10;

endpackage

// File: rtl/mseq_dispatch.sv
// Opcode dispatch ROMs for the two decode points of the microprogram.
// hit=0 means the opcode is not listed in the selected table (target=fetch).
module mseq_dispatch
  import mseq_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  tbl_e             tbl,
  output logic [MS_W-1:0]  target,
  output logic             hit
);

  // Table lookup; unlisted opcodes fall back to the fetch state.
  always_comb begin
    target = MS_W'(S_FETCH);
    hit    = 1'b1;
    if (tbl == TBL_DISP1) begin
      case (opcode)
        OP_LW, OP_SW: target = MS_W'(S_MEMADR);
        OP_R:         target = MS_W'(S_EXECUTER);
        OP_I:         target = MS_W'(S_EXECUTEI);
        OP_JAL:       target = MS_W'(S_JAL);
        OP_BEQ:       target = MS_W'(S_BEQ);
        default:      hit    = 1'b0;
      endcase
    end else begin
      case (opcode)
        OP_LW:   target = MS_W'(S_MEMREAD);
        OP_SW:   target = MS_W'(S_MEMWRITE);
        default: hit    = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registers the control-store address, counts
// retired instructions. Define MSEQ_ILLEGAL_TRAP_EN to trap unlisted
// dispatches, reserved seq codes and runaway NEXT into fetch with a
// sticky illegal flag; otherwise illegal is tied low.
module micro_sequencer
  import mseq_pkg::*;
#(
  parameter int unsigned UADDR_W   = 4,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SEQ_W-1:0]     seq,
  input  logic [OPC_W-1:0]     opcode,
  input  logic                 stall,
  output logic [UADDR_W-1:0]   upc,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  tbl_e                 tbl_sel_c;
  logic [MS_W-1:0]      disp_target_c;
  logic                 disp_hit_c;
  logic [UADDR_W-1:0]   next_upc_c;
  logic [UADDR_W-1:0]   upc_d;
  logic                 retire_d;
  logic [INSTRET_W-1:0] instret_d;

  assign tbl_sel_c = (seq == DISP2) ? TBL_DISP2 : TBL_DISP1;

  mseq_dispatch u_dispatch (
    .opcode (opcode),
    .tbl    (tbl_sel_c),
    .target (disp_target_c),
    .hit    (disp_hit_c)
  );

`ifdef MSEQ_ILLEGAL_TRAP_EN
  logic trap_c;
  logic illegal_d;

  // Conditions that send the microprogram somewhere it should never be.
  always_comb begin
    trap_c = 1'b0;
    case (seq)
      NEXT:         trap_c = (upc > UADDR_W'(S_BEQ));
      DISP1, DISP2: trap_c = !disp_hit_c;
      FETCH, ALUWB: trap_c = 1'b0;
      default:      trap_c = 1'b1;
    endcase
  end

  // Sticky flag; frozen while stalled.
  always_comb begin
    illegal_d = illegal;
    if (!stall && trap_c) illegal_d = 1'b1;
  end

  // Illegal flag register.
  always_ff @(posedge clk) begin
    if (reset) illegal <= 1'b0;
    else       illegal <= illegal_d;
  end
`else
  assign illegal = 1'b0;
`endif

  // Next microprogram address from the sequencing field.
  always_comb begin
    next_upc_c = UADDR_W'(S_FETCH);
    case (seq)
      NEXT:         next_upc_c = upc + UADDR_W'(1);
      DISP1, DISP2: next_upc_c = disp_hit_c ? UADDR_W'(disp_target_c) : UADDR_W'(S_FETCH);
      FETCH:        next_upc_c = UADDR_W'(S_FETCH);
      ALUWB:        next_upc_c = UADDR_W'(S_ALUWB);
      default:      next_upc_c = UADDR_W'(S_FETCH);
    endcase
`ifdef MSEQ_ILLEGAL_TRAP_EN
    if (trap_c) next_upc_c = UADDR_W'(S_FETCH);
`endif
  end

  // Register next values; a stall holds everything.
  always_comb begin
    upc_d     = upc;
    retire_d  = retire;
    instret_d = instret;
    if (!stall) begin
      upc_d    = next_upc_c;
      retire_d = (seq == FETCH);
      if (seq == FETCH) instret_d = instret + INSTRET_W'(1);
    end
  end

  // State registers; reset wins over stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      upc     <= '0;
      retire  <= 1'b0;
      instret <= '0;
    end else begin
      upc     <= upc_d;
      retire  <= retire_d;
      instret <= instret_d;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer (UADDR_W=4, INSTRET_W=4).
module tb_micro_sequencer;

  localparam int unsigned UADDR_W   = 4;
  localparam int unsigned INSTRET_W = 4;
`ifdef MSEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [2:0]           seq;
  logic [6:0]           opcode;
  logic                 stall;
  logic [UADDR_W-1:0]   upc;
  logic                 retire;
  logic [INSTRET_W-1:0] instret;
  logic                 illegal;

  micro_sequencer #(.UADDR_W(UADDR_W), .INSTRET_W(INSTRET_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .seq     (seq),
    .opcode  (opcode),
    .stall   (stall),
    .upc     (upc),
    .retire  (retire),
    .instret (instret),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] upc;
    logic       retire;
    logic [3:0] instret;
    logic       illegal;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_upc = '0;
  logic       m_ret = 1'b0;
  logic [3:0] m_ins = '0;
  logic       m_ill = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] disp_ref(input bit second, input logic [6:0] op, output bit hit);
    hit = 1'b1;
    if (!second) begin
      if (op == 7'b0000011 || op == 7'b0100011) return 4'd2;
      if (op == 7'b0110011) return 4'd6;
      if (op == 7'b0010011) return 4'd8;
      if (op == 7'b1101111) return 4'd9;
      if (op == 7'b1100011) return 4'd10;
    end else begin
      if (op == 7'b0000011) return 4'd3;
      if (op == 7'b0100011) return 4'd5;
    end
    hit = 1'b0;
    return 4'd0;
  endfunction

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic step(input logic [2:0] s, input logic [6:0] op, input logic st,
                      input logic rst, input string tag);
    exp_t       e;
    bit         trap;
    bit         hit;
    logic [3:0] nu;
    seq = s; opcode = op; stall = st; reset = rst;
    if (rst) begin
      m_upc = '0; m_ret = 1'b0; m_ins = '0; m_ill = 1'b0;
    end else if (!st) begin
      trap = 1'b0;
      case (s)
        3'd0: begin nu = m_upc + 4'd1; trap = (m_upc > 4'd10); end
        3'd1: begin nu = disp_ref(1'b0, op, hit); trap = !hit; end
        3'd2: begin nu = disp_ref(1'b1, op, hit); trap = !hit; end
        3'd3: nu = 4'd0;
        3'd4: nu = 4'd7;
        default: begin nu = 4'd0; trap = 1'b1; end
      endcase
      if (TRAP_EN && trap) begin nu = 4'd0; m_ill = 1'b1; end
      if (s == 3'd3) m_ins = m_ins + 4'd1;
      m_ret = (s == 3'd3);
      m_upc = nu;
    end
    e = '{upc: m_upc, retire: m_ret, instret: m_ins, illegal: m_ill};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".upc"},     32'(upc),     32'(e.upc));
    check({tag, ".retire"},  32'(retire),  32'(e.retire));
    check({tag, ".instret"}, 32'(instret), 32'(e.instret));
    check({tag, ".illegal"}, 32'(illegal), 32'(e.illegal));
  endtask

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  initial begin
    logic [6:0] ops [8];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
    ops[4] = 7'b1101111; ops[5] = 7'b1100011; ops[6] = 7'b1111111; ops[7] = 7'b0000000;

    reset = 1'b1; seq = '0; opcode = '0; stall = 1'b0;
    step(3'd0, 7'd0, 1'b0, 1'b1, "reset0");
    step(3'd0, 7'd0, 1'b1, 1'b1, "reset_stall");

    // lw flow: 0,1,2,3,4,0
    step(3'd0, LW, 1'b0, 1'b0, "lw0");
    step(3'd1, LW, 1'b0, 1'b0, "lw1");
    step(3'd2, LW, 1'b0, 1'b0, "lw2");
    step(3'd0, LW, 1'b0, 1'b0, "lw3");
    step(3'd3, LW, 1'b0, 1'b0, "lw4");
    check("lw.instret", 32'(instret), 32'd1);
    step(3'd0, LW, 1'b0, 1'b0, "lw_after");

    // R-type: reset then 0,1,6,7,0
    step(3'd0, RT, 1'b0, 1'b1, "r_rst");
    step(3'd0, RT, 1'b0, 1'b0, "r0");
    step(3'd1, RT, 1'b0, 1'b0, "r1");
    step(3'd4, RT, 1'b0, 1'b0, "r6");
    step(3'd3, RT, 1'b0, 1'b0, "r7");
    check("r.upc_fetch", 32'(upc), 32'd0);

    // Stall at upc=3 for 4 cycles, seq/opcode garbage meanwhile
    step(3'd0, LW, 1'b0, 1'b0, "st0");
    step(3'd1, LW, 1'b0, 1'b0, "st1");
    step(3'd2, LW, 1'b0, 1'b0, "st2");
    for (int i = 0; i < 4; i++) step(3'($urandom_range(0, 7)), 7'($urandom), 1'b1, 1'b0, "stall_hold");
    check("stall.upc3", 32'(upc), 32'd3);
    step(3'd0, LW, 1'b0, 1'b0, "st_release");
    check("stall.upc4", 32'(upc), 32'd4);
    step(3'd3, LW, 1'b0, 1'b0, "st_retire");
    step(3'd0, LW, 1'b1, 1'b0, "retire_hold");

    // Reset mid-flight at upc=6
    step(3'd0, RT, 1'b0, 1'b0, "mid0");
    step(3'd1, RT, 1'b0, 1'b0, "mid1");
    step(3'd3, RT, 1'b0, 1'b1, "mid_reset");
    check("mid.instret", 32'(instret), 32'd0);

    // Illegal opcode at DISP1, then sticky
    step(3'd0, BAD, 1'b0, 1'b0, "ill0");
    step(3'd1, BAD, 1'b0, 1'b0, "ill_disp1");
    step(3'd0, LW,  1'b0, 1'b0, "ill_sticky1");
    step(3'd3, LW,  1'b0, 1'b0, "ill_sticky2");
    step(3'd0, LW,  1'b0, 1'b1, "ill_clear");

    // Runaway NEXT past S_BEQ, then reserved codes
    step(3'd0, BEQ, 1'b0, 1'b0, "run0");
    step(3'd1, BEQ, 1'b0, 1'b0, "run_beq");
    step(3'd0, BEQ, 1'b0, 1'b0, "run_next10");
    step(3'd0, BEQ, 1'b0, 1'b0, "run_next11");
    step(3'd2, BEQ, 1'b0, 1'b1, "run_rst");
    step(3'd0, LW,  1'b0, 1'b0, "rsv0");
    step(3'd5, LW,  1'b0, 1'b0, "rsv5");
    step(3'd0, LW,  1'b0, 1'b0, "rsv_n");
    step(3'd7, LW,  1'b0, 1'b0, "rsv7");
    step(3'd0, LW,  1'b0, 1'b1, "wrap_rst");

    // instret wrap: 16 retires
    for (int i = 0; i < 16; i++) step(3'd3, LW, 1'b0, 1'b0, "wrap");
    check("wrap.zero", 32'(instret), 32'd0);

    // Random mix
    for (int i = 0; i < 300; i++)
      step(3'($urandom_range(0, 7)), ops[$urandom_range(0, 7)],
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 39) == 0), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001: Parameter UADDR_W, default 4, SHALL set the microprogram address width.
REQ-002: Parameter INSTRET_W, default 32, SHALL set the retired-instruction counter width.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005: seq  input  3  SHALL carry the sequencing field (low 3 bits) of the current microword.
REQ-006: opcode  input  7  SHALL carry instruction-register bits [6:0].
REQ-007: stall  input  1  SHALL be the memory-wait indication; 1 freezes sequencing.
REQ-008: upc  output  UADDR_W  SHALL be the registered microprogram address driven to the control store.
REQ-009: retire  output  1  SHALL pulse high for one cycle when an instruction completes.
REQ-010: instret  output  INSTRET_W  SHALL count completed instructions.
REQ-011: illegal  output  1  SHALL be a sticky illegal-dispatch flag (see Configuration).

Function
REQ-012: The sequencer SHALL compute next_upc combinationally from upc, seq and opcode, and register it; the control store is combinational, so upc-to-seq is zero latency and each microstate lasts one cycle unless stalled.
REQ-013: seq=000 (NEXT) SHALL give next_upc=upc+1 modulo 2^UADDR_W.
REQ-014: seq=001 (DISP1) SHALL map opcode: 0000011 (lw)->2, 0100011 (sw)->2, 0110011 (R)->6, 0010011 (I)->8, 1101111 (jal)->9, 1100011 (beq)->10; any other opcode->0.
REQ-015: seq=010 (DISP2) SHALL map opcode: 0000011->3, 0100011->5; any other opcode->0.
REQ-016: seq=011 (FETCH) SHALL give next_upc=0.
REQ-017: seq=100 (ALUWB) SHALL give next_upc=7.
REQ-018: Reserved seq codes 101/110/111 SHALL give next_upc=0.
REQ-019: With stall=1, upc, retire, instret and illegal SHALL hold their values; seq and opcode are ignored that cycle.
REQ-020: retire SHALL be registered and SHALL be 1 in the cycle after an edge where seq=011 and stall=0; otherwise 0.
REQ-021: instret SHALL increment by 1 on the same edge that sets retire, wrapping from all-ones to 0.
REQ-022: Reset and stall asserted together SHALL resolve as reset.

Reset
REQ-023: On a clock edge with reset=1, upc SHALL become 0 (the fetch state), and retire, instret and illegal SHALL become 0.
REQ-024: Reset asserted mid-instruction SHALL abandon that instruction without a retire pulse or an instret increment.

Configuration
REQ-025: With MSEQ_ILLEGAL_TRAP_EN defined, a DISP1 or DISP2 decode to the default (unlisted-opcode) case, a reserved seq code, or upc>10 under NEXT SHALL force next_upc=0 and set illegal=1 until reset.
REQ-026: Without MSEQ_ILLEGAL_TRAP_EN, those cases SHALL still resolve per REQ-013..018, and illegal SHALL be tied to 0.

Structure
REQ-027: Package mseq_pkg SHALL hold the seq enumeration (NEXT, DISP1, DISP2, FETCH, ALUWB), the opcode constants, and the named microstate addresses S_FETCH=0 through S_BEQ=10.
REQ-028: Combinational sub-module mseq_dispatch SHALL implement both dispatch tables (inputs opcode and table select; outputs target and hit flag); the counter and registers stay in micro_sequencer.

Verification
REQ-029: lw flow: reset, then seq sequence 000,001,010,000,011 with opcode=0000011 and stall=0 -> upc sequence 0,1,2,3,4,0; retire=1 once; instret=1.
REQ-030: R-type: opcode=0110011 with seq 000,001,100,011 -> upc 0,1,6,7,0; instret increments by 1.
REQ-031: Stall: at upc=3 hold stall=1 for 4 cycles -> upc stays 3 for all 4 cycles; on release, upc reaches 4 on the next edge.
REQ-032: Illegal opcode: opcode=1111111 at DISP1 -> upc=0 next cycle; illegal=1 and sticky with the macro, illegal=0 without it.
REQ-033: Reset mid-flight: reset at upc=6 -> upc=0 next cycle, retire=0, instret=0.
REQ-034: Counter wrap: preload instret to all-ones via 2^INSTRET_W retires (use INSTRET_W=4 in test) -> 16th retire gives instret=0.
